// File: rtl/sd_card_cmd_responder.sv
// sd_card_cmd_responder
//   Card-side model of the SD CMD line. Deserialises 48-bit host commands,
//   checks framing (and optionally CRC7), tracks the identification-mode card
//   state (idle/ready/ident/stby) and serialises R1/R2/R3/R6 responses.
//
//   Optional feature macro: SD_CMD_CRC_CHECK_EN
//     defined   : a CRC7 mismatch pulses crc_err and the frame is dropped
//     undefined : the received CRC field is ignored, crc_err stays 0
//
// Ports:
//   clk         system clock
//   resetn      synchronous, active-low reset
//   sd_clk_en   one-cycle tick marking an SD clock rising edge
//   cmd_in      CMD line as seen by the card
//   cmd_out     CMD value driven by the card
//   cmd_oe      tristate enable for cmd_out
//   cid         CID[127:8]; CRC7 and trailing bit are generated internally
//   card_state  0=idle, 1=ready, 2=ident, 3=stby
//   app_cmd     set by an accepted CMD55, cleared by the next accepted command
//   cmd_valid   one-cycle pulse when a frame is accepted
//   cmd_index   index of the last accepted frame
//   cmd_arg     argument of the last accepted frame
//   crc_err     one-cycle pulse on CRC7 mismatch
//   illegal     one-cycle pulse on an unsupported or wrong-state command

module sd_card_cmd_responder #(
   parameter logic [15:0] RCA      = 16'hF792,
   parameter logic [30:0] OCR      = 31'h00FF8000,
   parameter int unsigned BUSY_CNT = 1,
   parameter int unsigned NCR      = 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         sd_clk_en,
   input  logic         cmd_in,
   output logic         cmd_out,
   output logic         cmd_oe,
   input  logic [119:0] cid,
   output logic [3:0]   card_state,
   output logic         app_cmd,
   output logic         cmd_valid,
   output logic [5:0]   cmd_index,
   output logic [31:0]  cmd_arg,
   output logic         crc_err,
   output logic         illegal
);

   localparam logic [2:0] RX_IDLE  = 3'd0;
   localparam logic [2:0] RX_BITS  = 3'd1;
   localparam logic [2:0] DECODE   = 3'd2;
   localparam logic [2:0] WAIT_NCR = 3'd3;
   localparam logic [2:0] TX_BITS  = 3'd4;
   localparam logic [2:0] TX_END   = 3'd5;

   localparam logic [3:0] CS_IDLE  = 4'd0;
   localparam logic [3:0] CS_READY = 4'd1;
   localparam logic [3:0] CS_IDENT = 4'd2;
   localparam logic [3:0] CS_STBY  = 4'd3;

   logic [2:0]   state;
   logic [47:0]  rx_sr;
   logic [5:0]   rx_cnt;
   logic [6:0]   rx_crc;
   logic [135:0] tx_sr;
   logic [7:0]   tx_cnt;
   logic [7:0]   tx_len;
   logic [7:0]   crc_lo;
   logic [7:0]   crc_hi;
   logic         tx_gen;
   logic [6:0]   tx_crc;
   logic [6:0]   ncr_cnt;
   logic [7:0]   busy_cnt;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   logic        f_tx, f_end;
   logic [5:0]  f_idx;
   logic [31:0] f_arg;
   logic [6:0]  f_crc;
   logic        crc_bad;
   logic        frame_unused;

   assign f_tx  = rx_sr[46];
   assign f_end = rx_sr[0];
   assign f_idx = rx_sr[45:40];
   assign f_arg = rx_sr[39:8];
   assign f_crc = rx_sr[7:1];

`ifdef SD_CMD_CRC_CHECK_EN
   assign crc_bad      = (rx_crc != f_crc);
   assign frame_unused = rx_sr[47];
`else
   assign crc_bad      = 1'b0;
   assign frame_unused = ^{rx_sr[47], rx_crc, f_crc};
`endif

   // Next transmitted bit. The CRC field of R1/R6/R2 is held as zeros in
   // tx_sr; inside [crc_hi, crc_hi+6] the running CRC is shifted out instead,
   // and bits in [crc_lo, crc_hi) feed the running CRC as they go out.
   logic [7:0] tx_idx;
   logic       tx_ins;
   logic       tx_bit;
   logic [6:0] tx_crc_nxt;

   always_comb begin
      tx_idx     = (state == WAIT_NCR) ? 8'd0 : tx_cnt + 8'd1;
      tx_ins     = tx_gen && (tx_idx >= crc_hi) && (tx_idx < crc_hi + 8'd7);
      tx_bit     = tx_ins ? tx_crc[6] : tx_sr[135];
      tx_crc_nxt = tx_crc;
      if (tx_ins)
         tx_crc_nxt = {tx_crc[5:0], 1'b0};
      else if (tx_gen && (tx_idx >= crc_lo) && (tx_idx < crc_hi))
         tx_crc_nxt = crc7_step(tx_crc, tx_bit);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= RX_IDLE;
         cmd_out    <= 1'b1;
         cmd_oe     <= 1'b0;
         card_state <= CS_IDLE;
         app_cmd    <= 1'b0;
         busy_cnt   <= '0;
         cmd_index  <= '0;
         cmd_arg    <= '0;
         cmd_valid  <= 1'b0;
         crc_err    <= 1'b0;
         illegal    <= 1'b0;
         rx_sr      <= '0;
         rx_cnt     <= '0;
         rx_crc     <= '0;
         tx_sr      <= '0;
         tx_cnt     <= '0;
         tx_len     <= 8'd48;
         crc_lo     <= '0;
         crc_hi     <= '0;
         tx_gen     <= 1'b0;
         tx_crc     <= '0;
         ncr_cnt    <= '0;
      end else begin
         cmd_valid <= 1'b0;
         crc_err   <= 1'b0;
         illegal   <= 1'b0;
         // DECODE is a single clk cycle and does not wait for a tick.
         if (state == DECODE) begin
            state <= RX_IDLE;
            if (f_tx && f_end) begin
               if (crc_bad) begin
                  crc_err <= 1'b1;
               end else begin
                  cmd_valid <= 1'b1;
                  cmd_index <= f_idx;
                  cmd_arg   <= f_arg;
                  app_cmd   <= 1'b0;
                  ncr_cnt   <= '0;
                  tx_crc    <= '0;
                  tx_gen    <= 1'b1;
                  crc_lo    <= 8'd0;
                  crc_hi    <= 8'd40;
                  tx_len    <= 8'd48;
                  if (f_idx == 6'd0) begin
                     card_state <= CS_IDLE;
                     busy_cnt   <= '0;
                  end else if (f_idx == 6'd55) begin
                     app_cmd <= 1'b1;
                     tx_sr   <= {2'b00, f_idx, 19'd0, card_state, 3'b000, 1'b1, 5'd0,
                                 8'h01, 88'd0};
                     state   <= WAIT_NCR;
                  end else if (f_idx == 6'd41 && app_cmd && card_state == CS_IDLE) begin
                     tx_gen <= 1'b0;
                     state  <= WAIT_NCR;
                     if (32'(busy_cnt) < BUSY_CNT) begin
                        busy_cnt <= busy_cnt + 8'd1;
                        tx_sr    <= {2'b00, 6'h3F, 1'b0, OCR, 8'hFF, 88'd0};
                     end else begin
                        card_state <= CS_READY;
                        tx_sr      <= {2'b00, 6'h3F, 1'b1, OCR, 8'hFF, 88'd0};
                     end
                  end else if (f_idx == 6'd2 && card_state == CS_READY) begin
                     card_state <= CS_IDENT;
                     tx_sr      <= {2'b00, 6'h3F, cid, 8'h01};
                     crc_lo     <= 8'd8;
                     crc_hi     <= 8'd128;
                     tx_len     <= 8'd136;
                     state      <= WAIT_NCR;
                  end else if (f_idx == 6'd3 &&
                               (card_state == CS_IDENT || card_state == CS_STBY)) begin
                     card_state <= CS_STBY;
                     tx_sr      <= {2'b00, 6'd3, RCA, 16'h0000, 8'h01, 88'd0};
                     state      <= WAIT_NCR;
                  end else begin
                     illegal <= 1'b1;
                  end
               end
            end
         end else if (sd_clk_en) begin
            case (state)
               RX_IDLE: begin
                  if (!cmd_in && !cmd_oe) begin
                     state  <= RX_BITS;
                     rx_cnt <= 6'd1;
                     rx_sr  <= '0;
                     rx_crc <= '0;
                  end
               end
               RX_BITS: begin
                  rx_sr <= {rx_sr[46:0], cmd_in};
                  if (rx_cnt < 6'd40)
                     rx_crc <= crc7_step(rx_crc, cmd_in);
                  if (rx_cnt == 6'd47)
                     state <= DECODE;
                  else
                     rx_cnt <= rx_cnt + 6'd1;
               end
               WAIT_NCR: begin
                  if (ncr_cnt == 7'(NCR)) begin
                     state   <= TX_BITS;
                     cmd_oe  <= 1'b1;
                     cmd_out <= tx_bit;
                     tx_sr   <= tx_sr << 1;
                     tx_crc  <= tx_crc_nxt;
                     tx_cnt  <= tx_idx;
                  end else begin
                     ncr_cnt <= ncr_cnt + 7'd1;
                  end
               end
               TX_BITS: begin
                  if (tx_cnt == tx_len - 8'd1) begin
                     state   <= TX_END;
                     cmd_out <= 1'b1;
                  end else begin
                     cmd_out <= tx_bit;
                     tx_sr   <= tx_sr << 1;
                     tx_crc  <= tx_crc_nxt;
                     tx_cnt  <= tx_idx;
                  end
               end
               TX_END: begin
                  cmd_oe  <= 1'b0;
                  cmd_out <= 1'b1;
                  state   <= RX_IDLE;
               end
               default: state <= RX_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// tb_sd_card_cmd_responder
//   Self-checking bench for sd_card_cmd_responder. Acts as the host: serialises
//   command frames on ticks, collects responses, and compares everything with a
//   behavioural card model built from the command/response rules.

module tb_sd_card_cmd_responder;

   localparam logic [15:0]  P_RCA  = 16'hF792;
   localparam logic [30:0]  P_OCR  = 31'h00FF8000;
   localparam int unsigned  P_BUSY = 1;
   localparam int unsigned  P_NCR  = 2;
   localparam logic [119:0] CID    = 120'h7E4456BFAFE53C7AB12900000ECD;
`ifdef SD_CMD_CRC_CHECK_EN
   localparam bit CRC_CHECK = 1'b1;
`else
   localparam bit CRC_CHECK = 1'b0;
`endif

   localparam int K_DROP = 0;
   localparam int K_CRC  = 1;
   localparam int K_ILL  = 2;
   localparam int K_ACC  = 3;
   localparam int K_RESP = 4;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         sd_clk_en = 1'b0;
   logic         cmd_in = 1'b1;
   logic         cmd_out, cmd_oe;
   logic [119:0] cid = CID;
   logic [3:0]   card_state;
   logic         app_cmd, cmd_valid, crc_err, illegal;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_arg;

   always #5 clk = ~clk;

   sd_card_cmd_responder #(
      .RCA(P_RCA), .OCR(P_OCR), .BUSY_CNT(P_BUSY), .NCR(P_NCR)
   ) dut (
      .clk(clk), .resetn(resetn), .sd_clk_en(sd_clk_en), .cmd_in(cmd_in),
      .cmd_out(cmd_out), .cmd_oe(cmd_oe), .cid(cid), .card_state(card_state),
      .app_cmd(app_cmd), .cmd_valid(cmd_valid), .cmd_index(cmd_index),
      .cmd_arg(cmd_arg), .crc_err(crc_err), .illegal(illegal)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_valid  = 0;
   int n_crc    = 0;
   int n_ill    = 0;

   always @(negedge clk) begin
      if (cmd_valid) n_valid++;
      if (crc_err)   n_crc++;
      if (illegal)   n_ill++;
   end

   // card model
   logic [3:0]   m_state = 4'd0;
   logic         m_app   = 1'b0;
   int unsigned  m_busy  = 0;
   logic [5:0]   m_idx   = '0;
   logic [31:0]  m_arg   = '0;
   logic [135:0] last_resp = '0;

   // CRC7 as the remainder of msg(x)*x^7 divided by x^7+x^3+1 (long division).
   function automatic logic [6:0] crc7(input logic [127:0] msg, input int n);
      logic [135:0] r;
      r = {8'd0, msg} << 7;
      for (int i = n + 6; i >= 7; i--)
         if (r[i]) r = r ^ (136'h89 << (i - 7));
      return r[6:0];
   endfunction

   function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] h;
      h = {2'b01, idx, arg};
      return {h, crc7(128'(h), 40), 1'b1};
   endfunction

   task automatic predict(input logic [47:0] f, output int kind,
                          output logic [135:0] resp, output int len);
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [3:0]  prev;
      logic        app;
      logic [39:0] hdr;
      idx  = f[45:40];
      arg  = f[39:8];
      resp = '0;
      len  = 0;
      if (!f[46] || !f[0]) begin
         kind = K_DROP;
      end else if (CRC_CHECK && (f[7:1] != crc7(128'(f[47:8]), 40))) begin
         kind = K_CRC;
      end else begin
         m_idx = idx;
         m_arg = arg;
         prev  = m_state;
         app   = m_app;
         m_app = 1'b0;
         kind  = K_RESP;
         len   = 48;
         if (idx == 6'd0) begin
            m_state = 4'd0;
            m_busy  = 0;
            kind    = K_ACC;
         end else if (idx == 6'd55) begin
            m_app = 1'b1;
            hdr   = {2'b00, idx, 32'(prev) * 512 + 32'h20};
            resp  = 136'({hdr, crc7(128'(hdr), 40), 1'b1});
         end else if (idx == 6'd41 && app && m_state == 4'd0) begin
            if (m_busy < P_BUSY) begin
               m_busy++;
               resp = 136'({2'b00, 6'h3F, 1'b0, P_OCR, 7'h7F, 1'b1});
            end else begin
               m_state = 4'd1;
               resp = 136'({2'b00, 6'h3F, 1'b1, P_OCR, 7'h7F, 1'b1});
            end
         end else if (idx == 6'd2 && m_state == 4'd1) begin
            m_state = 4'd2;
            len     = 136;
            resp    = {2'b00, 6'h3F, CID, crc7(128'(CID), 120), 1'b1};
         end else if (idx == 6'd3 && (m_state == 4'd2 || m_state == 4'd3)) begin
            m_state = 4'd3;
            hdr     = {2'b00, 6'd3, P_RCA, 16'h0000};
            resp    = 136'({hdr, crc7(128'(hdr), 40), 1'b1});
         end else begin
            kind = K_ILL;
            len  = 0;
         end
      end
   endtask

   // One SD clock tick: drive b, pulse sd_clk_en, sample outputs half a clk later.
   // Between ticks cmd_in wiggles randomly; the card must ignore it.
   task automatic tick(input logic b, output logic o_oe, output logic o_out);
      int unsigned idle;
      idle = $urandom_range(1, 3);
      @(negedge clk);
      cmd_in    = b;
      sd_clk_en = 1'b1;
      @(negedge clk);
      sd_clk_en = 1'b0;
      o_oe  = cmd_oe;
      o_out = cmd_out;
      for (int unsigned k = 1; k < idle; k++) begin
         cmd_in = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [47:0] f);
      logic oe, out;
      for (int i = 47; i >= 0; i--) tick(f[i], oe, out);
   endtask

   task automatic run_cmd(input logic [47:0] f, input string name);
      int kind, len, v0, i0, c0, gap;
      logic [135:0] exp_r, got;
      logic oe, out, lost;
      v0 = n_valid;
      i0 = n_ill;
      c0 = n_crc;
      predict(f, kind, exp_r, len);
      send_frame(f);
      got = '0;
      if (kind == K_RESP) begin
         gap = 0;
         oe  = 1'b0;
         while (!oe && gap < 80) begin
            tick(1'($urandom_range(0, 1)), oe, out);
            if (!oe) gap++;
         end
         n_checks++;
         if (oe !== 1'b1) begin
            $display("FAIL %s response_start: cmd_oe stayed %b for %0d ticks, required 1", name, oe, gap);
            n_fail++;
         end else begin
            n_checks++;
            if (gap != int'(P_NCR)) begin
               $display("FAIL %s ncr_gap: got %0d ticks, required %0d", name, gap, P_NCR);
               n_fail++;
            end
            got  = 136'(out);
            lost = 1'b0;
            for (int i = 1; i < len; i++) begin
               tick(1'($urandom_range(0, 1)), oe, out);
               got = {got[134:0], out};
               if (oe !== 1'b1) lost = 1'b1;
            end
            last_resp = got;
            n_checks++;
            if (got !== exp_r) begin
               $display("FAIL %s response_bits: got %h, required %h", name, got, exp_r);
               n_fail++;
            end
            n_checks++;
            if (lost) begin
               $display("FAIL %s oe_during_response: got cmd_oe dropped, required held 1", name);
               n_fail++;
            end
            tick(1'($urandom_range(0, 1)), oe, out);
            n_checks++;
            if (oe !== 1'b1 || out !== 1'b1) begin
               $display("FAIL %s tx_end: got oe=%b out=%b, required oe=1 out=1", name, oe, out);
               n_fail++;
            end
            tick(1'($urandom_range(0, 1)), oe, out);
            n_checks++;
            if (oe !== 1'b0) begin
               $display("FAIL %s release: got cmd_oe=%b, required 0", name, oe);
               n_fail++;
            end
         end
      end else begin
         lost = 1'b0;
         for (int i = 0; i < int'(P_NCR) + 6; i++) begin
            tick(1'b1, oe, out);
            if (oe !== 1'b0) lost = 1'b1;
         end
         n_checks++;
         if (lost) begin
            $display("FAIL %s no_response: got cmd_oe=1, required 0", name);
            n_fail++;
         end
      end
      n_checks++;
      if (n_valid - v0 != ((kind >= K_ILL) ? 1 : 0)) begin
         $display("FAIL %s cmd_valid_pulses: got %0d, required %0d", name, n_valid - v0, (kind >= K_ILL) ? 1 : 0);
         n_fail++;
      end
      n_checks++;
      if (n_ill - i0 != ((kind == K_ILL) ? 1 : 0)) begin
         $display("FAIL %s illegal_pulses: got %0d, required %0d", name, n_ill - i0, (kind == K_ILL) ? 1 : 0);
         n_fail++;
      end
      n_checks++;
      if (n_crc - c0 != ((kind == K_CRC) ? 1 : 0)) begin
         $display("FAIL %s crc_err_pulses: got %0d, required %0d", name, n_crc - c0, (kind == K_CRC) ? 1 : 0);
         n_fail++;
      end
      n_checks++;
      if (cmd_index !== m_idx || cmd_arg !== m_arg) begin
         $display("FAIL %s last_cmd: got idx=%0d arg=%h, required idx=%0d arg=%h", name, cmd_index, cmd_arg, m_idx, m_arg);
         n_fail++;
      end
      n_checks++;
      if (card_state !== m_state || app_cmd !== m_app) begin
         $display("FAIL %s card_state/app_cmd: got %0d/%b, required %0d/%b", name, card_state, app_cmd, m_state, m_app);
         n_fail++;
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      cmd_in = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (cmd_out !== 1'b1 || cmd_oe !== 1'b0) begin
         $display("FAIL reset_cmd_line: got out=%b oe=%b, required out=1 oe=0", cmd_out, cmd_oe);
         n_fail++;
      end
      n_checks++;
      if (card_state !== 4'd0 || app_cmd !== 1'b0 || cmd_index !== 6'd0 || cmd_arg !== 32'd0) begin
         $display("FAIL reset_regs: got state=%0d app=%b idx=%0d arg=%h, required all 0", card_state, app_cmd, cmd_index, cmd_arg);
         n_fail++;
      end
      n_checks++;
      if ({cmd_valid, crc_err, illegal} !== 3'b000) begin
         $display("FAIL reset_pulses: got %b, required 000", {cmd_valid, crc_err, illegal});
         n_fail++;
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_cmd(48'h77_00_00_00_00_65, "cmd55");
      n_checks++;
      if (last_resp[45:8] !== {6'd55, 32'h00000020}) begin
         $display("FAIL cmd55_r1_fields: got %h, required %h", last_resp[45:8], {6'd55, 32'h00000020});
         n_fail++;
      end
      run_cmd(48'h69_40_00_00_00_77, "acmd41_busy");
      n_checks++;
      if (last_resp[39:8] !== 32'h00FF8000) begin
         $display("FAIL acmd41_busy_ocr: got %h, required 00ff8000", last_resp[39:8]);
         n_fail++;
      end
      run_cmd(48'h77_00_00_00_00_65, "cmd55_b");
      run_cmd(48'h69_40_00_00_00_77, "acmd41_ready");
      n_checks++;
      if (last_resp[39:8] !== 32'h80FF8000 || card_state !== 4'd1) begin
         $display("FAIL acmd41_ready_ocr: got %h state=%0d, required 80ff8000 state=1", last_resp[39:8], card_state);
         n_fail++;
      end
      run_cmd(48'h42_00_00_00_00_4D, "cmd2");
      n_checks++;
      if (last_resp[135:8] !== {8'h3F, CID}) begin
         $display("FAIL cmd2_r2_fields: got %h, required %h", last_resp[135:8], {8'h3F, CID});
         n_fail++;
      end
      run_cmd(48'h43_00_00_00_00_21, "cmd3");
      n_checks++;
      if (last_resp[47:8] !== {8'h03, 16'hF792, 16'h0000} || card_state !== 4'd3) begin
         $display("FAIL cmd3_r6_fields: got %h state=%0d, required %h state=3", last_resp[47:8], card_state, {8'h03, 16'hF792, 16'h0000});
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_response();
      logic oe, out;
      int t;
      send_frame(mk_frame(6'd55, 32'h0));
      t  = 0;
      oe = 1'b0;
      while (!oe && t < 40) begin
         tick(1'b1, oe, out);
         t++;
      end
      n_checks++;
      if (oe !== 1'b1) begin
         $display("FAIL midreset_start: got cmd_oe=%b, required 1", oe);
         n_fail++;
      end
      repeat (5) tick(1'b1, oe, out);
      @(negedge clk);
      cmd_in = 1'b1;
      resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cmd_oe !== 1'b0 || cmd_out !== 1'b1 || card_state !== 4'd0 || app_cmd !== 1'b0) begin
         $display("FAIL midreset_state: got oe=%b out=%b state=%0d app=%b, required 0 1 0 0", cmd_oe, cmd_out, card_state, app_cmd);
         n_fail++;
      end
      m_state = 4'd0;
      m_app   = 1'b0;
      m_busy  = 0;
      m_idx   = '0;
      m_arg   = '0;
   endtask

   task automatic test_crc_and_illegal();
      run_cmd(48'h77_00_00_00_00_64, "cmd55_endbit0");
      run_cmd(48'h77_00_00_00_00_67, "cmd55_badcrc");
      run_cmd(48'h40_00_00_00_00_95, "cmd0");
      run_cmd(48'h42_00_00_00_00_4D, "cmd2_in_idle");
   endtask

   task automatic test_random();
      logic [47:0] f;
      logic [5:0]  idx;
      int unsigned r, c;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2: idx = 6'd55;
            3, 7:    idx = 6'd41;
            4:       idx = 6'd2;
            5:       idx = 6'd3;
            6:       idx = 6'd0;
            default: idx = 6'($urandom_range(0, 63));
         endcase
         f = mk_frame(idx, $urandom);
         c = $urandom_range(0, 15);
         if (c == 0) f[46] = 1'b0;
         else if (c == 1) f[0] = 1'b0;
         else if (c == 2 || c == 3) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
         run_cmd(f, $sformatf("rand%0d_cmd%0d", n, idx));
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_reset_mid_response();
      test_crc_and_illegal();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
